// File: rtl/hbm_channel_rd_engine_if.sv
// Signal bundle for one pseudo-channel read engine: request entry, HBM beat
// issue, HBM line return and the per-core fan-out side.
interface hbm_channel_rd_engine_if #(
    parameter int HBM_AWIDTH     = 32,
    parameter int HBM_DWIDTH     = 256,
    parameter int GROUP_CORE_NUM = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int CNT_WIDTH      = 5
);
    // request entry (no ready; producer obeys stage_full)
    logic [HBM_AWIDTH-1:0]     front_rd_addr;
    logic [LEN_WIDTH-1:0]      front_rd_len;
    logic                      front_rd_valid;
    logic                      stage_full;

    // beat issue towards the HBM controller
    logic                      hbm_controller_full;
    logic [HBM_AWIDTH-1:0]     rd_hbm_addr;
    logic                      rd_hbm_valid;

    // returned lines
    logic [HBM_DWIDTH-1:0]     hbm_controller_edge;
    logic                      hbm_controller_valid;

    // core fan-out
    logic                      core_ready;
    logic [HBM_DWIDTH-1:0]     active_v_edge;
    logic [GROUP_CORE_NUM-1:0] active_v_edge_valid;

    // status
    logic [CNT_WIDTH-1:0]      outstanding_cnt;
    logic                      resp_err;

    // driver side: front-end, HBM controller model and cores
    modport master (
        output front_rd_addr, front_rd_len, front_rd_valid,
        output hbm_controller_full, hbm_controller_edge, hbm_controller_valid,
        output core_ready,
        input  stage_full, rd_hbm_addr, rd_hbm_valid,
        input  active_v_edge, active_v_edge_valid,
        input  outstanding_cnt, resp_err
    );

    // read engine side
    modport slave (
        input  front_rd_addr, front_rd_len, front_rd_valid,
        input  hbm_controller_full, hbm_controller_edge, hbm_controller_valid,
        input  core_ready,
        output stage_full, rd_hbm_addr, rd_hbm_valid,
        output active_v_edge, active_v_edge_valid,
        output outstanding_cnt, resp_err
    );
endinterface

// File: rtl/hbm_channel_rd_engine.sv
// Per-pseudo-channel HBM edge read engine.
// Queues multi-beat read requests, splits them into beats issued under credit
// control, buffers returned lines and fans them out to GROUP_CORE_NUM lanes
// with all-ones lanes masked as empty edge slots.
module hbm_channel_rd_engine #(
    parameter int                    HBM_AWIDTH       = 32,
    parameter int                    HBM_DWIDTH       = 256,
    parameter int                    GROUP_CORE_NUM   = 8,
    parameter int                    LEN_WIDTH        = 8,
    parameter logic [HBM_AWIDTH-1:0] ADDR_OFFSET      = '0,
    parameter int                    BEAT_BYTES       = 32,
    parameter int                    RQST_DEPTH       = 16,
    parameter int                    RESP_DEPTH       = 32,
    parameter int                    MAX_OUTSTANDING  = 16,
    parameter int                    PROG_FULL_THRESH = 12
) (
    input logic                    clk,
    input logic                    rst_n,
    hbm_channel_rd_engine_if.slave bus
);
    localparam int LW        = HBM_DWIDTH / GROUP_CORE_NUM;
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;
    localparam int RQ_AW     = $clog2(RQST_DEPTH);
    localparam int RS_AW     = $clog2(RESP_DEPTH);
    localparam int RQ_EW     = HBM_AWIDTH + LEN_WIDTH;

    localparam logic [HBM_AWIDTH-1:0] BEAT_INC     = HBM_AWIDTH'(BEAT_BYTES);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE      = LEN_WIDTH'(1);
    localparam logic [RQ_AW-1:0]      RQ_PTR_ONE   = RQ_AW'(1);
    localparam logic [RQ_AW-1:0]      RQ_PTR_LAST  = RQ_AW'(RQST_DEPTH - 1);
    localparam logic [RQ_AW:0]        RQ_CNT_ONE   = (RQ_AW + 1)'(1);
    localparam logic [RQ_AW:0]        RQ_CNT_FULL  = (RQ_AW + 1)'(RQST_DEPTH);
    localparam logic [RQ_AW:0]        RQ_CNT_PROG  = (RQ_AW + 1)'(PROG_FULL_THRESH);
    localparam logic [RS_AW-1:0]      RS_PTR_ONE   = RS_AW'(1);
    localparam logic [RS_AW-1:0]      RS_PTR_LAST  = RS_AW'(RESP_DEPTH - 1);
    localparam logic [RS_AW:0]        RS_CNT_ONE   = (RS_AW + 1)'(1);
    localparam logic [RS_AW:0]        RS_CNT_FULL  = (RS_AW + 1)'(RESP_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX      = CNT_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        IDLE,
        ISSUE
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO: entries hold {offset address, beat count (min 1)}
    // ------------------------------------------------------------------
    logic [RQ_EW-1:0]      rq_mem [RQST_DEPTH];
    logic [RQ_AW-1:0]      rq_wr_ptr;
    logic [RQ_AW-1:0]      rq_rd_ptr;
    logic [RQ_AW:0]        rq_count;
    logic [RQ_AW:0]        rq_count_nxt;
    logic                  rq_empty;
    logic                  rq_full;
    logic                  rq_wr;
    logic                  rq_pop;
    logic [LEN_WIDTH-1:0]  enq_len;
    logic [HBM_AWIDTH-1:0] head_addr;
    logic [LEN_WIDTH-1:0]  head_len;
    logic                  stage_full_q;

    assign rq_empty = (rq_count == '0);
    assign rq_full  = (rq_count == RQ_CNT_FULL);
    assign rq_wr    = bus.front_rd_valid && !rq_full;
    assign enq_len  = (bus.front_rd_len == '0) ? LEN_ONE : bus.front_rd_len;
    assign {head_addr, head_len} = rq_mem[rq_rd_ptr];

    // Next request FIFO occupancy, used both for the count and the registered stage_full.
    always_comb begin
        rq_count_nxt = rq_count;
        if (rq_wr && !rq_pop) begin
            rq_count_nxt = rq_count + RQ_CNT_ONE;
        end else if (!rq_wr && rq_pop) begin
            rq_count_nxt = rq_count - RQ_CNT_ONE;
        end
    end

    // Request storage write; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (rq_wr) begin
            rq_mem[rq_wr_ptr] <= {bus.front_rd_addr + ADDR_OFFSET, enq_len};
        end
    end

    // Request FIFO pointers, occupancy and stage_full flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rq_wr_ptr    <= '0;
            rq_rd_ptr    <= '0;
            rq_count     <= '0;
            stage_full_q <= 1'b0;
        end else begin
            if (rq_wr) begin
                rq_wr_ptr <= (rq_wr_ptr == RQ_PTR_LAST) ? '0 : rq_wr_ptr + RQ_PTR_ONE;
            end
            if (rq_pop) begin
                rq_rd_ptr <= (rq_rd_ptr == RQ_PTR_LAST) ? '0 : rq_rd_ptr + RQ_PTR_ONE;
            end
            rq_count     <= rq_count_nxt;
            stage_full_q <= (rq_count_nxt >= RQ_CNT_PROG);
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t                state;
    logic [HBM_AWIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  rd_valid_q;
    logic [HBM_AWIDTH-1:0] rd_addr_q;
    logic [CNT_WIDTH-1:0]  out_cnt;
    logic                  issue_ok;
    logic                  issue_fire;
    logic                  last_beat;

    assign issue_ok   = !bus.hbm_controller_full && (out_cnt < CNT_MAX);
    assign issue_fire = (state == ISSUE) && issue_ok;
    assign last_beat  = (remaining == LEN_ONE);
    // the last beat of a burst pops the next request in the same cycle so bursts chain without a bubble
    assign rq_pop     = !rq_empty && ((state == IDLE) || (issue_fire && last_beat));

    // Burst splitting and registered beat issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rq_empty) begin
                        cur_addr  <= head_addr;
                        remaining <= head_len;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_ok) begin
                        rd_valid_q <= 1'b1;
                        rd_addr_q  <= cur_addr;
                        if (last_beat) begin
                            if (!rq_empty) begin
                                cur_addr  <= head_addr;
                                remaining <= head_len;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cur_addr  <= cur_addr + BEAT_INC;
                            remaining <= remaining - LEN_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO (show-ahead head drives the cores)
    // ------------------------------------------------------------------
    logic [HBM_DWIDTH-1:0] rs_mem [RESP_DEPTH];
    logic [RS_AW-1:0]      rs_wr_ptr;
    logic [RS_AW-1:0]      rs_rd_ptr;
    logic [RS_AW:0]        rs_count;
    logic                  rs_empty;
    logic                  rs_full;
    logic                  consume;
    logic                  ret_seen;
    logic                  ret_ok;
    logic [CNT_WIDTH-1:0]  inflight;
    logic                  resp_err_q;

    assign rs_empty = (rs_count == '0);
    assign rs_full  = (rs_count == RS_CNT_FULL);
    assign consume  = !rs_empty && bus.core_ready;
    assign ret_seen = bus.hbm_controller_valid && (inflight != '0);
    assign ret_ok   = ret_seen && !rs_full;

    // Response storage write.
    always_ff @(posedge clk) begin
        if (ret_ok) begin
            rs_mem[rs_wr_ptr] <= bus.hbm_controller_edge;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_wr_ptr <= '0;
            rs_rd_ptr <= '0;
            rs_count  <= '0;
        end else begin
            if (ret_ok) begin
                rs_wr_ptr <= (rs_wr_ptr == RS_PTR_LAST) ? '0 : rs_wr_ptr + RS_PTR_ONE;
            end
            if (consume) begin
                rs_rd_ptr <= (rs_rd_ptr == RS_PTR_LAST) ? '0 : rs_rd_ptr + RS_PTR_ONE;
            end
            if (ret_ok && !consume) begin
                rs_count <= rs_count + RS_CNT_ONE;
            end else if (!ret_ok && consume) begin
                rs_count <= rs_count - RS_CNT_ONE;
            end
        end
    end

    // Credit, in-flight tracking and sticky protocol error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_cnt    <= '0;
            inflight   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (issue_fire && !consume) begin
                out_cnt <= out_cnt + CNT_ONE;
            end else if (!issue_fire && consume) begin
                out_cnt <= out_cnt - CNT_ONE;
            end
            if (issue_fire && !ret_seen) begin
                inflight <= inflight + CNT_ONE;
            end else if (!issue_fire && ret_seen) begin
                inflight <= inflight - CNT_ONE;
            end
            if ((bus.front_rd_valid && rq_full) || (bus.hbm_controller_valid && !ret_ok)) begin
                resp_err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fan-out: all-ones lanes are empty edge slots
    // ------------------------------------------------------------------
    logic [HBM_DWIDTH-1:0]     head_line;
    logic [GROUP_CORE_NUM-1:0] lane_valid;

    // Head line presentation and per-lane valid masking.
    always_comb begin
        head_line  = rs_empty ? '0 : rs_mem[rs_rd_ptr];
        lane_valid = '0;
        for (int unsigned k = 0; k < GROUP_CORE_NUM; k++) begin
            lane_valid[k] = !rs_empty && (head_line[k*LW +: LW] != '1);
        end
    end

    assign bus.stage_full          = stage_full_q;
    assign bus.rd_hbm_valid        = rd_valid_q;
    assign bus.rd_hbm_addr         = rd_addr_q;
    assign bus.active_v_edge       = head_line;
    assign bus.active_v_edge_valid = lane_valid;
    assign bus.outstanding_cnt     = out_cnt;
    assign bus.resp_err            = resp_err_q;
endmodule

// File: tb/tb_hbm_channel_rd_engine.sv
// Self-checking bench for hbm_channel_rd_engine: directed scenarios plus a
// randomized phase, all checked against a transaction-level reference model.
module tb_hbm_channel_rd_engine;
    localparam int          AW   = 32;
    localparam int          DW   = 256;
    localparam int          NC   = 8;
    localparam int          LENW = 8;
    localparam int          MAXO = 16;
    localparam int          CW   = 5;
    localparam logic [31:0] OFFS = 32'h100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hbm_channel_rd_engine_if #(
        .HBM_AWIDTH(AW), .HBM_DWIDTH(DW), .GROUP_CORE_NUM(NC),
        .LEN_WIDTH(LENW), .CNT_WIDTH(CW)
    ) bus ();

    hbm_channel_rd_engine #(
        .HBM_AWIDTH(AW), .HBM_DWIDTH(DW), .GROUP_CORE_NUM(NC), .LEN_WIDTH(LENW),
        .ADDR_OFFSET(OFFS), .BEAT_BYTES(32), .RQST_DEPTH(16), .RESP_DEPTH(32),
        .MAX_OUTSTANDING(MAXO), .PROG_FULL_THRESH(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int           due;
        logic [255:0] line;
    } ret_t;

    int           n_checks = 0;
    int           n_err    = 0;
    int           cyc      = 0;
    logic [31:0]  exp_addr_q[$];
    ret_t         pend_q[$];
    logic [255:0] line_q[$];
    int           model_out      = 0;
    int           model_inflight = 0;
    logic         model_err      = 1'b0;
    bit           rtn_en         = 1'b0;
    int           lat_max        = 3;
    int           log_cyc[$];
    logic [31:0]  log_addr[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lane_mask(input logic [255:0] l);
        logic [7:0] m;
        for (int k = 0; k < 8; k++) m[k] = (l[k*32 +: 32] != 32'hFFFF_FFFF);
        return m;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++)
            l[k*32 +: 32] = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
        return l;
    endfunction

    // one clock: check pre-edge view, cross the edge, update model, drive returns
    task automatic tick();
        bit           cons, acc, pre_full;
        int           pre_out;
        logic [255:0] hd;
        logic [31:0]  ea;
        ret_t         r;
        if (line_q.size() > 0) begin
            hd = line_q[0];
            chk("head_line", bus.active_v_edge, hd);
            chk("lane_valid", 256'(bus.active_v_edge_valid), 256'(lane_mask(hd)));
        end else begin
            chk("lane_valid_empty", 256'(bus.active_v_edge_valid), 256'(0));
        end
        chk("credits", 256'(bus.outstanding_cnt), 256'(model_out));
        cons     = (line_q.size() > 0) && bus.core_ready;
        acc      = bus.hbm_controller_valid && (model_inflight > 0);
        pre_full = bus.hbm_controller_full;
        pre_out  = model_out;
        if (bus.hbm_controller_valid && !acc) model_err = 1'b1;
        @(negedge clk);
        cyc++;
        bus.front_rd_valid = 1'b0;
        if (bus.rd_hbm_valid) begin
            chk("issue_allowed", 256'(!pre_full && (pre_out < MAXO)), 256'(1));
            chk("beat_pending", 256'(exp_addr_q.size() > 0), 256'(1));
            if (exp_addr_q.size() > 0) begin
                ea = exp_addr_q.pop_front();
                chk("beat_addr", 256'(bus.rd_hbm_addr), 256'(ea));
            end
            log_cyc.push_back(cyc);
            log_addr.push_back(bus.rd_hbm_addr);
            model_out++;
            model_inflight++;
            if (rtn_en) begin
                r.due  = cyc + int'($urandom_range(lat_max, 1));
                r.line = rand_line();
                pend_q.push_back(r);
            end
        end
        if (cons) begin
            model_out--;
            void'(line_q.pop_front());
        end
        if (acc) begin
            line_q.push_back(bus.hbm_controller_edge);
            model_inflight--;
        end
        chk("resp_err", 256'(bus.resp_err), 256'(model_err));
        if (rtn_en && (pend_q.size() > 0) && (pend_q[0].due <= cyc)) begin
            bus.hbm_controller_valid = 1'b1;
            bus.hbm_controller_edge  = pend_q[0].line;
            void'(pend_q.pop_front());
        end else begin
            bus.hbm_controller_valid = 1'b0;
        end
    endtask

    task automatic req(input logic [31:0] a, input int len);
        int n;
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) exp_addr_q.push_back(a + OFFS + 32'(i * 32));
        bus.front_rd_addr  = a;
        bus.front_rd_len   = len[7:0];
        bus.front_rd_valid = 1'b1;
        tick();
    endtask

    task automatic drain(input int budget);
        bit busy;
        busy = 1'b1;
        for (int i = 0; i < budget && busy; i++) begin
            tick();
            busy = (exp_addr_q.size() > 0) || (pend_q.size() > 0) ||
                   (line_q.size() > 0) || (model_inflight > 0);
        end
        chk("drain_timeout", 256'(busy), 256'(0));
    endtask

    task automatic do_reset();
        rst_n                    = 1'b0;
        bus.front_rd_valid       = 1'b0;
        bus.hbm_controller_valid = 1'b0;
        bus.hbm_controller_full  = 1'b0;
        bus.core_ready           = 1'b0;
        @(negedge clk);
        cyc++;
        exp_addr_q.delete();
        pend_q.delete();
        line_q.delete();
        model_out      = 0;
        model_inflight = 0;
        model_err      = 1'b0;
        chk("rst_rd_valid", 256'(bus.rd_hbm_valid), 256'(0));
        chk("rst_rd_addr", 256'(bus.rd_hbm_addr), 256'(0));
        chk("rst_stage_full", 256'(bus.stage_full), 256'(0));
        chk("rst_edge", bus.active_v_edge, 256'(0));
        chk("rst_lane_valid", 256'(bus.active_v_edge_valid), 256'(0));
        chk("rst_credits", 256'(bus.outstanding_cnt), 256'(0));
        chk("rst_resp_err", 256'(bus.resp_err), 256'(0));
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_addr.delete();
    endtask

    initial begin
        logic [31:0]  t1 [4];
        logic [31:0]  t2 [4];
        logic [255:0] ln;
        int           n0;

        t1 = '{32'h1100, 32'h1120, 32'h1140, 32'h1160};
        t2 = '{32'h2100, 32'h2120, 32'h3100, 32'h3120};
        bus.front_rd_addr        = '0;
        bus.front_rd_len         = '0;
        bus.front_rd_valid       = 1'b0;
        bus.hbm_controller_full  = 1'b0;
        bus.hbm_controller_edge  = '0;
        bus.hbm_controller_valid = 1'b0;
        bus.core_ready           = 1'b0;
        do_reset();

        // 1: single 4-beat burst with offset, consecutive beats
        rtn_en = 1'b1; lat_max = 3; bus.core_ready = 1'b1; clear_log();
        req(32'h1000, 4);
        drain(60);
        chk("t1_beats", 256'(log_addr.size()), 256'(4));
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("t1_addr", 256'(log_addr[i]), 256'(t1[i]));
            chk("t1_cycle", 256'(log_cyc[i] - log_cyc[0]), 256'(i));
        end

        // 2: two chained 2-beat requests, no bubble
        clear_log();
        req(32'h2000, 2);
        req(32'h3000, 2);
        drain(60);
        chk("t2_beats", 256'(log_addr.size()), 256'(4));
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("t2_addr", 256'(log_addr[i]), 256'(t2[i]));
            chk("t2_cycle", 256'(log_cyc[i] - log_cyc[0]), 256'(i));
        end

        // 4: controller full for 3 cycles mid-burst freezes issue
        clear_log();
        req(32'h4000, 8);
        tick(); tick(); tick();
        n0 = log_addr.size();
        bus.hbm_controller_full = 1'b1;
        tick(); tick(); tick();
        chk("t4_frozen", 256'(log_addr.size()), 256'(n0));
        bus.hbm_controller_full = 1'b0;
        drain(80);
        chk("t4_beats", 256'(log_addr.size()), 256'(8));
        for (int i = 0; i < 8 && i < log_addr.size(); i++)
            chk("t4_addr", 256'(log_addr[i]), 256'(32'h4100 + 32'(i * 32)));

        // 5: masked lane 2, then a fully masked line still pops
        rtn_en = 1'b0; bus.core_ready = 1'b0; clear_log();
        req(32'h5000, 1);
        for (int i = 0; i < 10 && log_addr.size() == 0; i++) tick();
        chk("t5_issued", 256'(log_addr.size()), 256'(1));
        for (int k = 0; k < 8; k++) ln[k*32 +: 32] = 32'h0101_0101 * 32'(k + 1);
        ln[64 +: 32] = 32'hFFFF_FFFF;
        bus.hbm_controller_valid = 1'b1;
        bus.hbm_controller_edge  = ln;
        tick();
        chk("t5_mask", 256'(bus.active_v_edge_valid), 256'(8'b1111_1011));
        tick();
        chk("t5_hold", 256'(bus.active_v_edge_valid), 256'(8'b1111_1011));
        bus.core_ready = 1'b1;
        tick();
        chk("t5_popped", 256'(bus.active_v_edge_valid), 256'(0));
        bus.core_ready = 1'b0; clear_log();
        req(32'h5100, 1);
        for (int i = 0; i < 10 && log_addr.size() == 0; i++) tick();
        bus.hbm_controller_valid = 1'b1;
        bus.hbm_controller_edge  = '1;
        tick();
        chk("t5_allmask", 256'(bus.active_v_edge_valid), 256'(0));
        chk("t5_allmask_cred", 256'(bus.outstanding_cnt), 256'(1));
        bus.core_ready = 1'b1;
        tick();
        chk("t5_allmask_pop", 256'(bus.outstanding_cnt), 256'(0));

        // 7: address wrap (0xFFFFFEE0 + 0x100 = 0xFFFFFFE0), plus len=0 as one beat
        rtn_en = 1'b1; clear_log();
        req(32'hFFFF_FEE0, 2);
        drain(60);
        chk("t7_beats", 256'(log_addr.size()), 256'(2));
        if (log_addr.size() == 2) begin
            chk("t7_addr0", 256'(log_addr[0]), 256'(32'hFFFF_FFE0));
            chk("t7_addr1", 256'(log_addr[1]), 256'(32'h0000_0000));
        end
        clear_log();
        req(32'h6000, 0);
        drain(60);
        chk("len0_beats", 256'(log_addr.size()), 256'(1));

        // 3: credit limit with cores stalled, then resume
        bus.core_ready = 1'b0; lat_max = 4; clear_log();
        req(32'h7000, 20);
        repeat (40) tick();
        chk("t3_cap", 256'(bus.outstanding_cnt), 256'(16));
        chk("t3_issued", 256'(log_addr.size()), 256'(16));
        bus.core_ready = 1'b1;
        drain(200);
        chk("t3_all", 256'(log_addr.size()), 256'(20));
        chk("t3_no_err", 256'(bus.resp_err), 256'(0));

        // stage_full threshold: 13 writes with one request popped
        bus.hbm_controller_full = 1'b1; clear_log();
        for (int i = 0; i < 12; i++) req(32'h8000 + 32'(i * 64), 1);
        chk("sf_below", 256'(bus.stage_full), 256'(0));
        req(32'h8400, 1);
        chk("sf_at", 256'(bus.stage_full), 256'(1));
        bus.hbm_controller_full = 1'b0;
        drain(200);
        chk("sf_clear", 256'(bus.stage_full), 256'(0));
        chk("sf_beats", 256'(log_addr.size()), 256'(13));

        // randomized traffic with backpressure on both sides
        lat_max = 6;
        for (int c = 0; c < 500; c++) begin
            bus.core_ready          = ($urandom_range(9, 0) < 7);
            bus.hbm_controller_full = ($urandom_range(9, 0) < 2);
            if ((exp_addr_q.size() < 12) && ($urandom_range(2, 0) == 0))
                req($urandom, int'($urandom_range(5, 0)));
            else
                tick();
        end
        bus.hbm_controller_full = 1'b0;
        bus.core_ready          = 1'b1;
        drain(300);

        // 6: reset mid-burst, then a stray return
        req(32'h9000, 10);
        repeat (4) tick();
        do_reset();
        rtn_en = 1'b0;
        bus.hbm_controller_valid = 1'b1;
        bus.hbm_controller_edge  = rand_line();
        tick();
        chk("t6_err", 256'(bus.resp_err), 256'(1));
        chk("t6_dropped", 256'(bus.active_v_edge_valid), 256'(0));
        tick();
        chk("t6_idle", 256'(bus.rd_hbm_valid), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
